// File: rtl/alu_pkg.sv
// Shared definitions for the M-extension divide/remainder sequencer:
// ALU control codes, FSM state names and op-decoding helpers.
package alu_pkg;

    localparam logic [5:0] DIV   = 6'b100011;
    localparam logic [5:0] DIVU  = 6'b100100;
    localparam logic [5:0] REM   = 6'b100101;
    localparam logic [5:0] REMU  = 6'b100110;
    localparam logic [5:0] DIVW  = 6'b101000;
    localparam logic [5:0] DIVUW = 6'b101001;
    localparam logic [5:0] REMW  = 6'b101010;
    localparam logic [5:0] REMUW = 6'b101011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    // True for any of the eight divide/remainder control codes.
    function automatic logic is_div_op(input logic [5:0] op);
        case (op)
            DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

    // Ops that interpret their operands as two's complement.
    function automatic logic isSignedOp(input logic [5:0] op);
        case (op)
            DIV, REM, DIVW, REMW: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    // Ops that return the remainder rather than the quotient.
    function automatic logic isRemOp(input logic [5:0] op);
        case (op)
            REM, REMU, REMW, REMUW: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    // 32-bit (W) variants.
    function automatic logic isWordOp(input logic [5:0] op);
        case (op)
            DIVW, DIVUW, REMW, REMUW: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    // Sign-extend a 32-bit word to 64 bits.
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left by one,
// trial-subtract the divisor from the widened partial remainder and keep
// the difference when it does not go negative.
module div_step #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic [BUS_DATA_WIDTH-1:0] rem,
    input  logic [BUS_DATA_WIDTH-1:0] quo,
    input  logic [BUS_DATA_WIDTH-1:0] divisor,
    output logic [BUS_DATA_WIDTH-1:0] remNext,
    output logic [BUS_DATA_WIDTH-1:0] quoNext
);

    // The partial remainder is always below the divisor, so only the shifted
    // trial value needs the extra bit; its top bit of the difference is the sign.
    logic [BUS_DATA_WIDTH:0] shifted;
    logic [BUS_DATA_WIDTH:0] diff;

    // Trial subtract and restore.
    always_comb begin
        shifted = {rem, quo[BUS_DATA_WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[BUS_DATA_WIDTH]) begin
            remNext = diff[BUS_DATA_WIDTH-1:0];
            quoNext = {quo[BUS_DATA_WIDTH-2:0], 1'b1};
        end else begin
            remNext = shifted[BUS_DATA_WIDTH-1:0];
            quoNext = {quo[BUS_DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle divide/remainder controller for the execute stage. Takes one
// op at a time, divides magnitudes one quotient bit per cycle and fixes the
// signs at the end. Special cases (divide by zero, signed overflow, non-div
// op codes) bypass the iteration loop entirely.
module div_sequencer
    import alu_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [5:0]                in_op,
    input  logic [BUS_DATA_WIDTH-1:0] in_a,
    input  logic [BUS_DATA_WIDTH-1:0] in_b,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BUS_DATA_WIDTH-1:0] out_result,
    output logic                      busy
);

    localparam int XLEN = BUS_DATA_WIDTH;

    localparam logic [2:0] stIdle = 3'(IDLE);
    localparam logic [2:0] stPrep = 3'(PREP);
    localparam logic [2:0] stCalc = 3'(CALC);
    localparam logic [2:0] stFix  = 3'(FIX);
    localparam logic [2:0] stDone = 3'(DONE);

    // Most-negative values as seen after W operands are sign-extended.
    localparam logic [XLEN-1:0] mostNeg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] mostNegW = {{(XLEN-31){1'b1}}, 31'b0};

    logic [2:0]      state;
    logic [5:0]      opReg;
    logic            isW;
    logic [XLEN-1:0] aReg;
    logic [XLEN-1:0] bReg;
    logic [XLEN-1:0] remReg;
    logic [XLEN-1:0] quoReg;
    logic [5:0]      cnt;
    logic            negQ;
    logic            negR;
    logic [XLEN-1:0] resultReg;

    logic [XLEN-1:0] aIn, bIn;
    logic            signA, signB;
    logic [XLEN-1:0] absA, absB;
    logic            divZero, overflow, special;
    logic [XLEN-1:0] specialRaw, specialRes;
    logic [XLEN-1:0] qFinal, rFinal, fixSel, fixRes;
    logic [XLEN-1:0] remNext, quoNext;

    assign in_ready   = (state == stIdle);
    assign busy       = (state != stIdle);
    assign out_valid  = (state == stDone);
    assign out_result = resultReg;

    // Operand shaping at accept time: W ops keep the low word, extended per signedness.
    always_comb begin
        aIn = in_a;
        bIn = in_b;
        if (isWordOp(in_op)) begin
            if (isSignedOp(in_op)) begin
                aIn = sext32(in_a[31:0]);
                bIn = sext32(in_b[31:0]);
            end else begin
                aIn = {{(XLEN-32){1'b0}}, in_a[31:0]};
                bIn = {{(XLEN-32){1'b0}}, in_b[31:0]};
            end
        end
    end

    // Magnitudes, sign bookkeeping and special-case detection for PREP.
    always_comb begin
        signA    = isSignedOp(opReg) & aReg[XLEN-1];
        signB    = isSignedOp(opReg) & bReg[XLEN-1];
        absA     = signA ? (~aReg + 1'b1) : aReg;
        absB     = signB ? (~bReg + 1'b1) : bReg;
        divZero  = (bReg == '0);
        overflow = isSignedOp(opReg) && (&bReg) && (aReg == (isW ? mostNegW : mostNeg));
        special  = !is_div_op(opReg) || divZero || overflow;

        specialRaw = '0;
        if (!is_div_op(opReg))
            specialRaw = '0;
        else if (divZero)
            specialRaw = isRemOp(opReg) ? aReg : '1;
        else if (overflow)
            specialRaw = isRemOp(opReg) ? '0 : aReg;
        specialRes = isW ? sext32(specialRaw[31:0]) : specialRaw;
    end

    // Final sign fix-up and quotient/remainder selection for FIX.
    always_comb begin
        qFinal = negQ ? (~quoReg + 1'b1) : quoReg;
        rFinal = negR ? (~remReg + 1'b1) : remReg;
        fixSel = isRemOp(opReg) ? rFinal : qFinal;
        fixRes = isW ? sext32(fixSel[31:0]) : fixSel;
    end

    div_step #(
        .BUS_DATA_WIDTH(XLEN)
    ) u_step (
        .rem    (remReg),
        .quo    (quoReg),
        .divisor(bReg),
        .remNext(remNext),
        .quoNext(quoNext)
    );

    // Control FSM and datapath registers; flush wins over everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= stIdle;
            opReg     <= '0;
            isW       <= 1'b0;
            aReg      <= '0;
            bReg      <= '0;
            remReg    <= '0;
            quoReg    <= '0;
            cnt       <= '0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            resultReg <= '0;
        end else if (flush) begin
            state <= stIdle;
        end else begin
            case (state)
                stIdle: begin
                    if (in_valid) begin
                        opReg <= in_op;
                        isW   <= isWordOp(in_op);
                        aReg  <= aIn;
                        bReg  <= bIn;
                        state <= stPrep;
                    end
                end
                stPrep: begin
                    negQ <= signA ^ signB;
                    negR <= signA;
                    if (special) begin
                        resultReg <= specialRes;
                        state     <= stDone;
                    end else begin
                        remReg <= '0;
                        // W dividends sit in the top word so 32 shifts consume them.
                        quoReg <= isW ? {absA[31:0], 32'b0} : absA;
                        bReg   <= absB;
                        cnt    <= isW ? 6'd31 : 6'd63;
                        state  <= stCalc;
                    end
                end
                stCalc: begin
                    remReg <= remNext;
                    quoReg <= quoNext;
                    if (cnt == 6'd0)
                        state <= stFix;
                    else
                        cnt <= cnt - 6'd1;
                end
                stFix: begin
                    resultReg <= fixRes;
                    state     <= stDone;
                end
                stDone: begin
                    if (out_ready)
                        state <= stIdle;
                end
                default: state <= stIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer. A driver issues ops and
// queues the expected result and latency from an arithmetic reference model;
// an independent monitor pops and compares whenever out_valid is presented.
module tb_div_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        busy;

    always #5 clk = ~clk;

    div_sequencer #(.BUS_DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t   sb[$];
    int     vectors = 0;
    int     miscompares = 0;
    longint cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void check64(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    function automatic void checkInt(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    function automatic void checkBit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endfunction

    // Reference model: plain language-level arithmetic plus the architectural
    // rules for divide-by-zero and signed overflow.
    function automatic logic [63:0] refResult(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        longint      sa  = a;
        longint      sb2 = b;
        int          a32 = a[31:0];
        int          b32 = b[31:0];
        int unsigned ua  = a[31:0];
        int unsigned ub  = b[31:0];
        int          r32;
        logic [63:0] r64;
        logic        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        logic        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        r32 = 0;
        r64 = '0;
        case (op)
            DIV:   begin if (b == 0) r64 = '1; else if (ovf64) r64 = a; else r64 = sa / sb2; end
            DIVU:  begin if (b == 0) r64 = '1; else r64 = a / b; end
            REM:   begin if (b == 0) r64 = a; else if (ovf64) r64 = '0; else r64 = sa % sb2; end
            REMU:  begin if (b == 0) r64 = a; else r64 = a % b; end
            DIVW:  begin if (b32 == 0) r32 = -1; else if (ovf32) r32 = a32; else r32 = a32 / b32; r64 = longint'(r32); end
            DIVUW: begin if (ub == 0) r32 = -1; else r32 = int'(ua / ub); r64 = longint'(r32); end
            REMW:  begin if (b32 == 0) r32 = a32; else if (ovf32) r32 = 0; else r32 = a32 % b32; r64 = longint'(r32); end
            REMUW: begin if (ub == 0) r32 = int'(ua); else r32 = int'(ua % ub); r64 = longint'(r32); end
            default: r64 = '0;
        endcase
        return r64;
    endfunction

    // Expected edges from accept to first out_valid cycle.
    function automatic int refLatency(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        bit word  = (op == DIVW) || (op == DIVUW) || (op == REMW) || (op == REMUW);
        bit sgn64 = (op == DIV) || (op == REM);
        bit sgn32 = (op == DIVW) || (op == REMW);
        bit valid = word || sgn64 || (op == DIVU) || (op == REMU);
        bit zero  = word ? (b[31:0] == 0) : (b == 0);
        bit ovf   = (sgn64 && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) ||
                    (sgn32 && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        if (!valid || zero || ovf) return 1;
        return word ? 34 : 66;
    endfunction

    // Monitor: compare whenever the DUT presents a result.
    logic [63:0] heldRes;
    bit          seen = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 0;
        end else if (out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_output: got out_valid with %h, required no output", out_result);
                    heldRes = out_result;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check64("result", out_result, e.res);
                    checkInt("latency", int'(cycle - e.acc), e.lat);
                    heldRes = e.res;
                end
                seen = 1;
            end else begin
                check64("held_result", out_result, heldRes);
            end
        end else begin
            seen = 0;
        end
    end

    task automatic acceptOp(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got in_ready 0, required 1");
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = refResult(op, a, b);
        e.lat = refLatency(op, a, b);
        e.acc = cycle;
        if (push) sb.push_back(e);
        $display("op %b a %h b %h expect %h lat %0d%s", op, a, b, e.res, e.lat, push ? "" : " (killed)");
    endtask

    task automatic waitDrain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic runOp(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b);
        acceptOp(op, a, b, 1'b1);
        waitDrain();
    endtask

    function automatic logic [63:0] randOperand();
        case ($urandom_range(0, 5))
            0: return {$urandom(), $urandom()};
            1: return 64'($urandom_range(0, 50));
            2: return 64'h0;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            default: return {{32{1'b1}}, $urandom()};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    logic [5:0] opTable[9];
    initial begin
        opTable = '{DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW, 6'b000111};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        checkBit("rst_in_ready", in_ready, 1'b1);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_out_valid", out_valid, 1'b0);
        check64("rst_out_result", out_result, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        runOp(DIV,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        runOp(REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        runOp(DIVU,  64'd5, 64'd0);
        runOp(REMU,  64'd5, 64'd0);
        runOp(DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        runOp(REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        runOp(DIVW,  64'h1_8000_0000, 64'hFFFF_FFFF);
        runOp(DIVUW, 64'hFFFF_FFFF, 64'd1);

        // flush beats a same-cycle request in IDLE.
        @(negedge clk);
        in_valid = 1'b1; in_op = DIV; in_a = 64'd10; in_b = 64'd3; flush = 1'b1;
        @(posedge clk);
        #1;
        checkBit("flush_blocks_accept", busy, 1'b0);
        in_valid = 1'b0;
        flush    = 1'b0;

        // Backpressure: result and busy held while out_ready is low.
        out_ready = 1'b0;
        acceptOp(DIVU, 64'd100, 64'd7, 1'b1);
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            checkBit("bp_valid_seen", out_valid, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            checkBit("bp_busy", busy, 1'b1);
            checkBit("bp_valid", out_valid, 1'b1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkBit("bp_in_ready", in_ready, 1'b1);
        runOp(REMU, 64'd100, 64'd7);

        // Flush in the middle of CALC: no output, then normal service resumes.
        acceptOp(DIV, 64'd1000, 64'd7, 1'b0);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        checkBit("flush_busy", busy, 1'b0);
        checkBit("flush_valid", out_valid, 1'b0);
        flush = 1'b0;
        repeat (80) @(negedge clk);
        runOp(DIV, 64'd9, 64'd3);

        // Asynchronous reset in the middle of CALC.
        acceptOp(DIVU, 64'd12345, 64'd11, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkBit("arst_in_ready", in_ready, 1'b1);
        checkBit("arst_busy", busy, 1'b0);
        checkBit("arst_out_valid", out_valid, 1'b0);
        check64("arst_out_result", out_result, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  op;
            logic [63:0] a, b;
            op = opTable[$urandom_range(0, 8)];
            a  = randOperand();
            b  = randOperand();
            if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(1, 9));
            runOp(op, a, b);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller for the M-extension divide/remainder ops in the execute stage: div, divu, rem, remu, divw, divuw, remw and remuw.
- Accepts one operation via valid/ready.
- Runs a radix-2 restoring divide, one quotient bit per cycle, and returns a 64-bit result via valid/ready.
- Its busy output stalls the upstream pipeline while an operation is in flight; flush kills the operation in flight.

Parameters:
- BUS_DATA_WIDTH, 64: operand and result width (XLEN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_op  in  6  ALU control code: 100011 div, 100100 divu, 100101 rem, 100110 remu, 101000 divw, 101001 divuw, 101010 remw, 101011 remuw.
- in_a  in  BUS_DATA_WIDTH  dividend, already forwarded.
- in_b  in  BUS_DATA_WIDTH  divisor, already forwarded.
- flush  in  1  kill the operation in flight (branch mispredict or trap).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  BUS_DATA_WIDTH  quotient or remainder.
- busy  out  1  high when the state is not IDLE; drives the pipeline stall.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; all datapath registers = 0.
  - Outputs: out_valid = 0, out_result = 0, busy = 0, in_ready = 1.
  - Reset mid-operation drops the operation; no result is ever presented.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE → PREP on (in_valid && in_ready && !flush).
  - Latch op, and the W flag (N = 32 for W ops, else 64).
  - For W ops use a[31:0] and b[31:0]; signed W ops sign-extend them.
- PREP (1 cycle):
  - Compute |a| and |b| for signed ops. Record neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
  - Detect special cases; any special case goes to DONE with the result loaded directly:
    - Divide by zero: quotient = all ones; remainder = dividend.
    - Signed overflow (most-negative / -1, at width N): quotient = dividend; remainder = 0.
    - in_op outside the div set: result = 0.
  - Otherwise load remainder register = 0 and shift register = |a|, iteration counter = N-1; → CALC.
- CALC (exactly N cycles):
  - Each cycle shift {rem, quo} left by 1.
  - Trial-subtract |b|; if non-negative, commit the difference and set the quotient LSB = 1.
  - Counter decrements; → FIX when the counter = 0.
- FIX (1 cycle):
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select quotient or remainder by op.
  - W ops: result = sign-extend of bits [31:0], including divuw and remuw.
  - → DONE.
- DONE:
  - out_valid = 1, with out_result held stable.
  - On out_ready → IDLE; otherwise hold DONE indefinitely (backpressure).
- Latency, counted in edges from the accept edge to the first cycle with out_valid high:
  - 64-bit ops: N+2 = 66.
  - W ops: 34.
  - Special cases: 1.
- Throughput:
  - One operation in flight at a time.
  - A new operation is accepted no earlier than the edge after the one that completes the DONE handshake, because in_ready is low in DONE.
- Flush:
  - Synchronous; from any non-IDLE state → IDLE on the next edge.
  - out_valid drops on that edge.
  - flush has priority over an acceptance in the same cycle (the request is not taken) and over out_ready.
- Division uses magnitudes only; no division operator is inferred. Remainder width is N+1 bits for the trial subtract.

Decomposition:
- Package alu_pkg holds:
  - localparam op codes DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW (6-bit);
  - typedef enum logic [2:0] div_state_t {IDLE, PREP, CALC, FIX, DONE};
  - helper function is_div_op(op).
- Sub-module div_step: a combinational single restoring iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Instantiated once in div_sequencer.

Test Plan:
- div a=-7, b=2 → out_result 0xFFFF_FFFF_FFFF_FFFD (-3), out_valid 66 edges after accept; rem with the same operands → 0xFFFF_FFFF_FFFF_FFFF (-1).
- divu a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF with latency 1; remu a=5, b=0 → 5.
- div a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000; rem → 0.
- divw a=0x1_8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 (overflow path); divuw a=0xFFFF_FFFF, b=1 → 0xFFFF_FFFF_FFFF_FFFF after 34 edges.
- divu a=100, b=7, out_ready held low for 5 cycles after out_valid:
  - out_result stays 14 and busy stays 1;
  - handshake completes → in_ready high the next cycle;
  - a back-to-back remu a=100, b=7 → 2.
- Kill and reset mid-operation:
  - flush asserted in CALC iteration 10 → IDLE next edge, no out_valid ever; a subsequent div a=9, b=3 → 3.
  - rst_n pulsed low mid-CALC → all outputs immediately return to their reset values.
